// File: rtl/regfile_seq_pkg.sv
// Shared definitions for the sequential register-file processor slice:
// default data width, opcode constants and the FSM state encoding.
package regfile_seq_pkg;

  localparam int DW_DEFAULT = 16;

  localparam logic [2:0] MV  = 3'b000;
  localparam logic [2:0] MVI = 3'b001;
  localparam logic [2:0] ADD = 3'b010;
  localparam logic [2:0] SUB = 3'b011;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2
  } state_t;

  // add/sub are the only two-step instructions
  function automatic logic is_alu(input logic [2:0] op);
    return (op == ADD) || (op == SUB);
  endfunction

endpackage

// File: rtl/regfile_seq_reg_bank.sv
// Seven-entry register bank R1..R7 with a flat output; address 0 has no
// storage, so writes to it are dropped.
module reg_bank
  import regfile_seq_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [2:0]      waddr,
  input  logic [DW-1:0]   wdata,
  output logic [7*DW-1:0] regs
);

  // Single-port write into the addressed register, async clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else if (we && (waddr != 3'd0)) begin
      regs[(int'(waddr) - 1) * DW +: DW] <= wdata;
    end
  end

endmodule

// File: rtl/regfile_seq.sv
// Sequential register-file datapath controller: fetches a 9-bit instruction
// on RUN, steers the external bus mux via SEL and writes results into the
// register bank (mv/mvi in one step, add/sub in two).
module regfile_seq
  import regfile_seq_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic            CLOCK,
  input  logic            RESETN,
  input  logic [DW-1:0]   DIN,
  input  logic            RUN,
  input  logic [DW-1:0]   BUS,
  output logic [2:0]      SEL,
  output logic [7*DW-1:0] REGS,
  output logic            DONE,
  output logic            BUSY
);

  state_t        state;
  logic [8:0]    ir;
  logic [DW-1:0] a;
  logic          we;
  logic [DW-1:0] wdata;
  logic          din_unused;

  wire [2:0] op = ir[8:6];
  wire [2:0] rx = ir[5:3];
  wire [2:0] ry = ir[2:0];

  // Upper instruction bits carry no meaning; immediates arrive via BUS
  assign din_unused = ^DIN[DW-1:9];

  // Bus-mux select decoded from state and IR only
  always_comb begin
    SEL = 3'd0;
    case (state)
      T1: begin
        if (op == MV)       SEL = ry;
        else if (is_alu(op)) SEL = rx;
        else                SEL = 3'd0;
      end
      T2:      SEL = ry;
      default: SEL = 3'd0;
    endcase
  end

  // Register-bank write request: end of T1 for moves, end of T2 for ALU ops
  always_comb begin
    we    = 1'b0;
    wdata = BUS;
    if (state == T1 && (op == MV || op == MVI)) begin
      we    = 1'b1;
      wdata = BUS;
    end else if (state == T2) begin
      we    = 1'b1;
      wdata = (op == SUB) ? (a - BUS) : (a + BUS);
    end
  end

  // Control FSM with registered DONE/BUSY; DONE is set on entry to the
  // final step so it is high during that step's cycle
  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      state <= T0;
      ir    <= '0;
      a     <= '0;
      DONE  <= 1'b0;
      BUSY  <= 1'b0;
    end else begin
      case (state)
        T0: begin
          DONE <= 1'b0;
          if (RUN) begin
            ir    <= DIN[8:0];
            state <= T1;
            BUSY  <= 1'b1;
            DONE  <= !is_alu(DIN[8:6]);
          end
        end
        T1: begin
          if (is_alu(op)) begin
            a     <= BUS;
            state <= T2;
            DONE  <= 1'b1;
          end else begin
            state <= T0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
          end
        end
        T2: begin
          state <= T0;
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
        end
        default: begin
          state <= T0;
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
        end
      endcase
    end
  end

  reg_bank #(.DW(DW)) u_bank (
    .clk   (CLOCK),
    .rst_n (RESETN),
    .we    (we),
    .waddr (rx),
    .wdata (wdata),
    .regs  (REGS)
  );

endmodule

// File: doc/regfile_seq.md
REGFILE_SEQ -- requirements
Module: regfile_seq

Interface
REQ-001 The block SHALL have parameter DW, default 16, meaning the data/register width.
REQ-002 The block SHALL have port CLOCK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RESETN, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port DIN, input, DW bits: instruction word in T0, immediate operand in T1 for mvi.
REQ-005 The block SHALL have port RUN, input, 1 bit: start request, sampled only in state T0.
REQ-006 The block SHALL have port BUS, input, DW bits: the bus-mux output, i.e. DIN when SEL=0, else R[SEL].
REQ-007 The block SHALL have port SEL, output, 3 bits: the bus-mux select.
REQ-008 The block SHALL have port REGS, output, 7*DW bits: flat R1..R7, with R1 at [DW-1:0] and Rk at [k*DW-1:(k-1)*DW].
REQ-009 The block SHALL have port DONE, output, 1 bit: instruction-complete pulse.
REQ-010 The block SHALL have port BUSY, output, 1 bit: high in any state other than T0.

Function
REQ-011 The FSM SHALL have three states: T0 (idle/fetch), T1 and T2.
REQ-012 In T0 with RUN=1, the block SHALL latch IR<=DIN[8:0] (op=IR[8:6], X=IR[5:3], Y=IR[2:0]) and go to T1; in T0 with RUN=0 it SHALL hold.
REQ-013 Opcode 000, mv Rx,Ry: T1 SEL=Y; Rx<=BUS at the end of T1; DONE=1 in T1; next state T0.
REQ-014 Opcode 001, mvi Rx,#D: T1 SEL=0, so BUS=DIN=D; Rx<=BUS at the end of T1; DONE=1 in T1; next state T0.
REQ-015 Opcode 010, add Rx,Ry: T1 SEL=X, A<=BUS; T2 SEL=Y, Rx<=A+BUS modulo 2^DW with carry discarded; DONE=1 in T2; next state T0.
REQ-016 Opcode 011, sub Rx,Ry: as add, but Rx<=A-BUS modulo 2^DW with borrow discarded.
REQ-017 Opcodes 100-111 SHALL be NOPs: no register write; DONE=1 in T1; next state T0.
REQ-018 Writes with X=0 SHALL be discarded (there is no R0 in the bank); DONE and timing SHALL be unchanged.
REQ-019 Y=0 (or X=0 as a source) SHALL read DIN through the mux; the upstream source is required to hold DIN valid during those cycles.
REQ-020 In T0, SEL SHALL be 0; SEL SHALL be a registered/decoded function of state and IR only, never of BUS.
REQ-021 Register-write latency SHALL be: mv/mvi, write at the 2nd rising edge after the RUN edge; add/sub, the 3rd.
REQ-022 RUN SHALL be ignored while BUSY=1; a RUN held high in the DONE cycle SHALL start the next instruction in the following T0 cycle, giving at most one idle cycle between instructions.
REQ-023 DONE SHALL be high for exactly one cycle per accepted instruction.
REQ-024 At most one register SHALL be written per cycle; unwritten registers SHALL hold their value.

Reset
REQ-025 When RESETN=0, the block SHALL immediately set: state=T0, IR=0, A=0, R1..R7=0, SEL=0, DONE=0, BUSY=0.
REQ-026 Reset asserted mid-instruction SHALL abort it with no partial write; after release the block SHALL wait in T0 for RUN.
REQ-027 Reset release SHALL be the only reset event; the first RUN is accepted on the first rising edge with RESETN=1.

Structure
REQ-028 A shared package SHALL hold the opcode constants (MV, MVI, ADD, SUB), the state encoding and DW.
REQ-029 The 7-entry register bank SHALL be one sub-module, reg_bank (write enable, 3-bit write address, data, flat REGS output, async active-low clear).
REQ-030 The FSM, IR, A and ALU SHALL reside in regfile_seq.

Verification
REQ-031 Reset, then mvi R1,#0x1234 (DIN=0x048 then 0x1234): R1=0x1234 after the 2nd edge, DONE pulses once, other registers stay 0.
REQ-032 mvi R2,#0xFFFF; mvi R3,#0x0001; add R2,R3: R2=0x0000 (wrap), DONE is high in T2 only.
REQ-033 R4=5, R5=7, sub R4,R5: R4=0xFFFE; then mv R6,R4: R6=0xFFFE with 2-cycle latency.
REQ-034 mvi R0,#0xAAAA and opcode 111: no register changes, DONE pulses in T1, and a RUN pulse while BUSY is ignored.
REQ-035 RESETN pulsed low during T2 of add R1,R2: R1 is unchanged (0), state=T0, DONE=0.
REQ-036 RUN held high for 4 back-to-back mvi instructions: a DONE every 2 cycles, with correct values in R1..R4.
